// File: rtl/turn_signal_input_cond.sv
// Input conditioning front end for the turn-signal/hazard LED controller.
// Latency: SYNC + up to DEB_TICKS*DIV_MAX clk cycles raw-to-level; stupid_in follows one strobe after the debounced press.
// Backpressure: none; free-running, every output is a register updated only on the div_clk rising-edge cycle.
//
// Build option: define INPUT_SYNC_EN for a two-flop synchroniser per raw input;
// without it a single input register is used (simulation / already-synchronous sources).
//
// Ports:
//   clk        system clock
//   rst        synchronous active-low reset
//   l_raw, r_raw, halt_raw, stupid_raw   raw asynchronous switch inputs
//   div_clk    divided clock, DIV_MAX clk cycles per period, 50% duty
//   tick       one-clk strobe coincident with each div_clk rise
//   l, r, halt debounced levels
//   stupid_in  one div_clk period long request per debounced press
module turn_signal_input_cond #(
    parameter int DIV_MAX   = 8,
    parameter int DEB_TICKS = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic l_raw,
    input  logic r_raw,
    input  logic halt_raw,
    input  logic stupid_raw,
    output logic div_clk,
    output logic tick,
    output logic l,
    output logic r,
    output logic halt,
    output logic stupid_in
);

    localparam int H   = DIV_MAX / 2;
    localparam int CW  = $clog2(DIV_MAX);
    localparam int DW  = $clog2(DEB_TICKS + 1);
    localparam int NCH = 4;             // l, r, halt, stupid
    localparam int S_IDX = 3;           // channel index of the stupid button

    // ------------------------------------------------------------------
    // Divider
    // ------------------------------------------------------------------
    logic [CW-1:0] cnt_q, cnt_d;
    logic          div_q, div_d;
    logic          tick_q, tick_d;
    logic          strobe;
    logic          wrap;

    // The strobe is the cycle before div_clk rises; everything that samples
    // or updates does so here so outputs move at the div_clk mid-period.
    assign strobe = (cnt_q == CW'(H - 1));
    assign wrap   = (cnt_q == CW'(DIV_MAX - 1));

    always_comb begin
        cnt_d  = wrap ? '0 : cnt_q + CW'(1);
        div_d  = (strobe || wrap) ? ~div_q : div_q;
        tick_d = strobe;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= '0;
            div_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    // ------------------------------------------------------------------
    // Input synchronisation
    // ------------------------------------------------------------------
    logic [NCH-1:0] raw_vec;
    logic [NCH-1:0] sync_q;

    assign raw_vec = {stupid_raw, halt_raw, r_raw, l_raw};

`ifdef INPUT_SYNC_EN
    logic [NCH-1:0] meta_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= raw_vec;
            sync_q <= meta_q;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= raw_vec;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Debounce: a level flips only after DEB_TICKS consecutive strobes
    // disagree with it; any agreeing strobe restarts the count.
    // ------------------------------------------------------------------
    logic [DW-1:0]  deb_cnt_q [NCH];
    logic [DW-1:0]  deb_cnt_d [NCH];
    logic [NCH-1:0] deb_q, deb_d;

    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < NCH; i++) begin
            deb_cnt_d[i] = deb_cnt_q[i];
            if (strobe) begin
                if (sync_q[i] == deb_q[i]) begin
                    deb_cnt_d[i] = '0;
                end else if (deb_cnt_q[i] == DW'(DEB_TICKS - 1)) begin
                    deb_d[i]     = sync_q[i];
                    deb_cnt_d[i] = '0;
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            deb_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            deb_q <= deb_d;
            for (int i = 0; i < NCH; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stupid request: one debounced rise arms a request that is presented
    // for exactly one strobe-to-strobe interval.
    // ------------------------------------------------------------------
    logic s_prev_q;
    logic s_rise;
    logic armed_q, armed_d;
    logic stup_q, stup_d;

    assign s_rise = deb_q[S_IDX] & ~s_prev_q;

    always_comb begin
        armed_d = armed_q;
        stup_d  = stup_q;
        if (strobe) begin
            stup_d  = armed_q;
            // A rise landing on the strobe itself is kept for the next one.
            armed_d = s_rise;
        end else if (s_rise) begin
            armed_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s_prev_q <= 1'b0;
            armed_q  <= 1'b0;
            stup_q   <= 1'b0;
        end else begin
            s_prev_q <= deb_q[S_IDX];
            armed_q  <= armed_d;
            stup_q   <= stup_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign div_clk   = div_q;
    assign tick      = tick_q;
    assign l         = deb_q[0];
    assign r         = deb_q[1];
    assign halt      = deb_q[2];
    assign stupid_in = stup_q;

endmodule

// File: tb/tb_turn_signal_input_cond.sv
module tb_turn_signal_input_cond;

    localparam int DIV_MAX   = 8;
    localparam int DEB_TICKS = 3;
    localparam int H         = DIV_MAX / 2;
`ifdef INPUT_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic l_raw = 1'b0, r_raw = 1'b0, halt_raw = 1'b0, stupid_raw = 1'b0;
    logic div_clk, tick, l, r, halt, stupid_in;

    turn_signal_input_cond #(.DIV_MAX(DIV_MAX), .DEB_TICKS(DEB_TICKS)) dut (
        .clk        (clk),
        .rst        (rst),
        .l_raw      (l_raw),
        .r_raw      (r_raw),
        .halt_raw   (halt_raw),
        .stupid_raw (stupid_raw),
        .div_clk    (div_clk),
        .tick       (tick),
        .l          (l),
        .r          (r),
        .halt       (halt),
        .stupid_in  (stupid_in)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got {div,tick,l,r,halt,stupid}=%b expected %b", name, $time, act, exp);
        end
    endtask

    function automatic logic [5:0] dut_vec();
        return {div_clk, tick, l, r, halt, stupid_in};
    endfunction

    // ------------------------------------------------------------------
    // Reference model: time measured as clk edges since reset release,
    // debounce as "last DEB_TICKS strobe samples all disagree",
    // request as "debounced press seen at the previous strobe".
    // ------------------------------------------------------------------
    int         m_n = 0;
    bit         m_div = 0, m_tick = 0, m_stup = 0, m_pend = 0;
    bit  [3:0]  m_deb = '0;
    bit  [3:0]  m_dly [0:SYNC-1];
    bit  [3:0]  m_hist [$];

    task automatic model_step();
        bit [3:0] samp;
        bit       old_s;
        bit       flip;
        int       nc;
        if (!rst) begin
            m_n = 0; m_div = 0; m_tick = 0; m_stup = 0; m_pend = 0; m_deb = '0;
            for (int k = 0; k < SYNC; k++) m_dly[k] = '0;
            m_hist.delete();
        end else begin
            if ((m_n % DIV_MAX) == H - 1) begin
                samp = m_dly[SYNC-1];
                m_hist.push_back(samp);
                if (m_hist.size() > DEB_TICKS) void'(m_hist.pop_front());
                old_s = m_deb[3];
                for (int c = 0; c < 4; c++) begin
                    flip = (m_hist.size() == DEB_TICKS);
                    foreach (m_hist[k]) if (m_hist[k][c] == m_deb[c]) flip = 0;
                    if (flip) m_deb[c] = samp[c];
                end
                m_stup = m_pend;
                m_pend = !old_s && m_deb[3];
            end
            for (int k = SYNC - 1; k > 0; k--) m_dly[k] = m_dly[k-1];
            m_dly[0] = {stupid_raw, halt_raw, r_raw, l_raw};
            m_n++;
            nc     = m_n % DIV_MAX;
            m_div  = (nc >= H);
            m_tick = (nc == H);
        end
    endtask

    initial begin
        for (int k = 0; k < SYNC; k++) m_dly[k] = '0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) check("model", dut_vec(), {m_div, m_tick, m_deb[0], m_deb[1], m_deb[2], m_stup});
    end

    // ------------------------------------------------------------------
    // Directed table: inputs held for cyc edges, outputs checked after.
    // exp = {div_clk, tick, l, r, halt, stupid_in}
    // ------------------------------------------------------------------
    typedef struct {
        logic       rst, l, r, h, s;
        int         cyc;
        logic [5:0] exp;
    } vec_t;

    localparam int NV = 25;
    vec_t tbl [NV];

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  5, 6'b000000}; // in reset
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  3, 6'b000000}; // cnt=3
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  1, 6'b110000}; // first rise
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  1, 6'b100000};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  3, 6'b000000}; // fall at 8
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 19, 6'b000000}; // l: 2 strobes
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0,  1, 6'b111000}; // l: 3rd strobe
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16, 6'b111000}; // halt glitch
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24, 6'b111000};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16, 6'b111000}; // counter was cleared
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0,  8, 6'b111000};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24, 6'b110000}; // l falls
        tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 23, 6'b000000}; // l,r together
        tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0,  1, 6'b111100};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 31, 6'b001100}; // press
        tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1,  1, 6'b111101}; // request starts
        tbl[16] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1,  7, 6'b001101};
        tbl[17] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1,  1, 6'b111100}; // ends after 8
        tbl[18] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 80, 6'b111100}; // held: no repeat
        tbl[19] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24, 6'b111100}; // release
        tbl[20] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32, 6'b111101}; // second press
        tbl[21] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0,  1, 6'b000000}; // reset mid-request
        tbl[22] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 19, 6'b000000};
        tbl[23] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0,  1, 6'b111100}; // 3 fresh strobes
        tbl[24] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0,  8, 6'b111100}; // no residual request

        for (int i = 0; i < NV; i++) begin
            rst        = tbl[i].rst;
            l_raw      = tbl[i].l;
            r_raw      = tbl[i].r;
            halt_raw   = tbl[i].h;
            stupid_raw = tbl[i].s;
            repeat (tbl[i].cyc) @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d", i), dut_vec(), tbl[i].exp);
            chk_en = 1'b1;
        end

        // Hand sequence: tick spacing is exactly DIV_MAX over several periods.
        begin
            int first, seen, cyc_i;
            first = -1; seen = 0; cyc_i = 0;
            while (seen < 4 && cyc_i < 6 * DIV_MAX) begin
                @(negedge clk);
                cyc_i++;
                if (tick) begin
                    if (first >= 0) check("tick_spacing", 6'(cyc_i - first), 6'(DIV_MAX));
                    first = cyc_i;
                    seen++;
                end
            end
            if (seen < 4) check("tick_timeout", 6'(seen), 6'd4);
        end

        // Randomised phase checked against the model every cycle.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 39) == 0) l_raw      = ~l_raw;
            if ($urandom_range(0, 39) == 0) r_raw      = ~r_raw;
            if ($urandom_range(0, 39) == 0) halt_raw   = ~halt_raw;
            if ($urandom_range(0, 29) == 0) stupid_raw = ~stupid_raw;
            if (rst && $urandom_range(0, 599) == 0) rst = 1'b0;
            else if (!rst && $urandom_range(0, 1) == 0) rst = 1'b1;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
